// File: rtl/seq_mult_pkg.sv
// Shared types and sizing helpers for the sequential shift-add multiplier.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Counter width CNT_W = $clog2(WIDTH); WIDTH is 2..32 so the result is never 0.
  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/seq_mult_ctrl.sv
// Control FSM and bit counter: one multiplier bit retired per RUN cycle.
module seq_mult_ctrl
  import seq_mult_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic             step_o,
  output logic             last_o,
  output logic [CNT_W-1:0] cnt_o,
  output state_e           state_o
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // DONE accepts a new start just like IDLE so back-to-back ops lose no cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        if (start_i) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o  = (state_q != S_IDLE);
  assign valid_o = (state_q == S_DONE);
  assign step_o  = (state_q == S_RUN);
  assign last_o  = step_o && (cnt_q == CNT_W'(WIDTH - 1));
  assign cnt_o   = cnt_q;
  assign state_o = state_q;

endmodule

// File: rtl/seq_mult.sv
// Sequential shift-add multiplier, signed or unsigned per operation, 2*WIDTH product.
module seq_mult
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               valid,
  output logic [2*WIDTH-1:0] out
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam int PW    = 2 * WIDTH;

  logic             step, last, load;
  logic [CNT_W-1:0] cnt;
  state_e           state;

  logic [WIDTH-1:0] a_q, b_q;
  logic             sm_q;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    out_q;
  logic [PW-1:0]    ext_a, term;

  seq_mult_ctrl #(.WIDTH(WIDTH)) u_ctrl (
    .clk     (clk),
    .rst     (rst),
    .start_i (start),
    .busy_o  (busy),
    .valid_o (valid),
    .step_o  (step),
    .last_o  (last),
    .cnt_o   (cnt),
    .state_o (state)
  );

  // A start is taken whenever the FSM is not mid-RUN (IDLE or DONE).
  assign load  = start && (state != S_RUN);
  assign ext_a = {{WIDTH{sm_q & a_q[WIDTH-1]}}, a_q};
  assign term  = ext_a << cnt;

  // In signed mode the multiplier MSB carries negative weight, hence the subtract.
  always_comb begin
    acc_d = acc_q;
    if (step && b_q[cnt]) begin
      if (sm_q && last) acc_d = acc_q - term;
      else              acc_d = acc_q + term;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      sm_q  <= 1'b0;
      acc_q <= '0;
      out_q <= '0;
    end else begin
      if (load) begin
        a_q   <= a;
        b_q   <= b;
        sm_q  <= signed_mode;
        acc_q <= '0;
      end else begin
        acc_q <= acc_d;
      end
      if (last) out_q <= acc_d;
    end
  end

  assign out = out_q;

endmodule
